rlight_multi: RTL and testbench

- Parametrised running-light peripheral on the TL-UL register bus, driving NumLeds LED outputs.
- Software loads a pattern, selects a mode (off, rotate left, rotate right, ping-pong) and sets a prescaler. The block advances the pattern once per prescaler period.
- Sits on the peripheral crossbar as a TL-UL slave.
- Adds over the previous generation: parametrised width, a working prescaler, ping-pong, live output readback and a step counter.

---
 rtl/rlight_pkg.sv | 30 +++
 rtl/tlul_pkg.sv | 47 ++++
 rtl/rlight_prescaler.sv | 38 +++
 rtl/tlul_adapter_reg.sv | 89 ++++++++
 rtl/rlight_multi.sv | 178 +++++++++++++++++
 tb/tb_rlight_multi.sv | 293 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/rlight_pkg.sv
// ============================================================================
// Package : rlight_pkg
// Brief   : Register offsets and mode/direction encodings of the running light.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package rlight_pkg;

    localparam logic [7:0] ADDR_PATTERN = 8'h00;
    localparam logic [7:0] ADDR_MODE    = 8'h04;
    localparam logic [7:0] ADDR_PRESC   = 8'h08;
    localparam logic [7:0] ADDR_OUTPUT  = 8'h0C;
    localparam logic [7:0] ADDR_STEPS   = 8'h10;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_ROTL     = 2'd1,
        MODE_ROTR     = 2'd2,
        MODE_PINGPONG = 2'd3
    } rlight_mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } rlight_dir_e;

endpackage

`default_nettype wire

// File: rtl/tlul_pkg.sv
// ============================================================================
// Package : tlul_pkg
// Brief   : TL-UL channel types shared by bus masters and register slaves.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

`default_nettype wire

// File: rtl/rlight_prescaler.sv
// ============================================================================
// Module : rlight_prescaler
// Brief  : Free-running divider producing a one-cycle tick every limit+1 cycles.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rlight_prescaler #(
    parameter int PRESC_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_clr,
    input  logic [PRESC_W-1:0] i_limit,
    output logic               o_tick
);

    logic [PRESC_W-1:0] r_cnt;
    logic               w_hit;

    assign w_hit  = i_en & (r_cnt == i_limit);
    // A clear restarts the period, so the coincident tick is swallowed.
    assign o_tick = w_hit & ~i_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tlul_adapter_reg.sv
// ============================================================================
// Module : tlul_adapter_reg
// Brief  : TL-UL to register-interface bridge, one outstanding access.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlul_adapter_reg
    import tlul_pkg::*;
#(
    parameter int RegAw = 8,
    parameter int RegDw = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  tl_h2d_t              tl_i,
    output tl_d2h_t              tl_o,
    output logic                 re_o,
    output logic                 we_o,
    output logic [RegAw-1:0]     addr_o,
    output logic [RegDw-1:0]     wdata_o,
    output logic [RegDw/8-1:0]   be_o,
    input  logic                 busy_i,
    input  logic [RegDw-1:0]     rdata_i,
    input  logic                 error_i
);

    logic             r_outstanding;
    tl_d_op_e         r_opcode;
    logic [1:0]       r_size;
    logic [7:0]       r_source;
    logic [RegDw-1:0] r_rdata;
    logic             r_error;

    logic w_a_ready;
    logic w_a_ack;
    logic w_is_wr;
    logic w_is_rd;
    logic w_unused_tl;

    assign w_a_ready = ~r_outstanding & ~busy_i;
    assign w_a_ack   = tl_i.a_valid & w_a_ready;
    assign w_is_wr   = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    assign w_is_rd   = (tl_i.a_opcode == Get);

    assign we_o    = w_a_ack & w_is_wr;
    assign re_o    = w_a_ack & w_is_rd;
    assign addr_o  = {tl_i.a_address[RegAw-1:2], 2'b00};
    assign wdata_o = tl_i.a_data;
    assign be_o    = tl_i.a_mask;

    assign w_unused_tl = ^{tl_i.a_param, tl_i.a_address[31:RegAw], tl_i.a_address[1:0]};

    // Read data is captured on acceptance, so the response holds the value
    // the registers had in the request cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outstanding <= 1'b0;
            r_opcode      <= AccessAck;
            r_size        <= 2'd0;
            r_source      <= 8'd0;
            r_rdata       <= '0;
            r_error       <= 1'b0;
        end else if (w_a_ack) begin
            r_outstanding <= 1'b1;
            r_opcode      <= w_is_rd ? AccessAckData : AccessAck;
            r_size        <= tl_i.a_size;
            r_source      <= tl_i.a_source;
            r_rdata       <= w_is_rd ? rdata_i : '0;
            r_error       <= error_i | ~(w_is_wr | w_is_rd);
        end else if (tl_i.d_ready) begin
            r_outstanding <= 1'b0;
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = r_outstanding;
        tl_o.d_opcode = r_opcode;
        tl_o.d_size   = r_size;
        tl_o.d_source = r_source;
        tl_o.d_data   = r_rdata;
        tl_o.d_error  = r_error;
        tl_o.a_ready  = w_a_ready;
    end

endmodule

`default_nettype wire

// File: rtl/rlight_multi.sv
// ============================================================================
// Module : rlight_multi
// Brief  : TL-UL running-light peripheral with rotate/ping-pong modes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rlight_multi
    import rlight_pkg::*;
#(
    parameter int NumLeds = 8,
    parameter int PrescW  = 32,
    parameter int RegAw   = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  tlul_pkg::tl_h2d_t    tl_i,
    output tlul_pkg::tl_d2h_t    tl_o,
    output logic [NumLeds-1:0]   led_o
);

    localparam int c_idx_w = (NumLeds > 2) ? $clog2(NumLeds) : 1;
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NumLeds - 2);
    localparam logic [NumLeds-1:0] c_pattern_rst = NumLeds'((32'd1 << (NumLeds / 2)) - 32'd1);

    localparam logic [RegAw-1:0] c_a_pattern = RegAw'(ADDR_PATTERN);
    localparam logic [RegAw-1:0] c_a_mode    = RegAw'(ADDR_MODE);
    localparam logic [RegAw-1:0] c_a_presc   = RegAw'(ADDR_PRESC);
    localparam logic [RegAw-1:0] c_a_output  = RegAw'(ADDR_OUTPUT);
    localparam logic [RegAw-1:0] c_a_steps   = RegAw'(ADDR_STEPS);

    logic             w_rst_n;
    logic             w_re;
    logic             w_we;
    logic [RegAw-1:0] w_addr;
    logic [31:0]      w_wdata;
    logic [3:0]       w_be;
    logic [31:0]      w_rdata;
    logic             w_unused_bus;

    logic w_wr_pattern;
    logic w_wr_mode;
    logic w_wr_presc;
    logic w_wr_steps;
    logic w_tick;

    logic [NumLeds-1:0] r_pattern;
    rlight_mode_e       r_mode;
    logic [PrescW-1:0]  r_presc;
    logic [NumLeds-1:0] r_led;
    logic [31:0]        r_steps;
    rlight_dir_e        r_dir;
    logic [c_idx_w-1:0] r_idx;

    logic [NumLeds-1:0] w_led_nxt;
    rlight_dir_e        w_dir_nxt;
    logic [c_idx_w-1:0] w_idx_nxt;

    function automatic logic [NumLeds-1:0] rot_l(input logic [NumLeds-1:0] v);
        return {v[NumLeds-2:0], v[NumLeds-1]};
    endfunction

    function automatic logic [NumLeds-1:0] rot_r(input logic [NumLeds-1:0] v);
        return {v[0], v[NumLeds-1:1]};
    endfunction

    assign w_rst_n = ~rst_i;

    tlul_adapter_reg #(
        .RegAw (RegAw),
        .RegDw (32)
    ) u_reg_if (
        .clk_i   (clk_i),
        .rst_ni  (w_rst_n),
        .tl_i    (tl_i),
        .tl_o    (tl_o),
        .re_o    (w_re),
        .we_o    (w_we),
        .addr_o  (w_addr),
        .wdata_o (w_wdata),
        .be_o    (w_be),
        .busy_i  (1'b0),
        .rdata_i (w_rdata),
        .error_i (1'b0)
    );

    assign w_unused_bus = ^{w_be, w_wdata};

    assign w_wr_pattern = w_we && (w_addr == c_a_pattern);
    assign w_wr_mode    = w_we && (w_addr == c_a_mode);
    assign w_wr_presc   = w_we && (w_addr == c_a_presc);
    assign w_wr_steps   = w_we && (w_addr == c_a_steps);

    rlight_prescaler #(
        .PRESC_W (PrescW)
    ) u_presc (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_en    (r_mode != MODE_OFF),
        .i_clr   (w_wr_pattern | w_wr_mode),
        .i_limit (r_presc),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_rdata = '0;
        if (w_re) begin
            case (w_addr)
                c_a_pattern: w_rdata = 32'(r_pattern);
                c_a_mode:    w_rdata = 32'(r_mode);
                c_a_presc:   w_rdata = 32'(r_presc);
                c_a_output:  w_rdata = 32'(r_led);
                c_a_steps:   w_rdata = r_steps;
                default:     w_rdata = '0;
            endcase
        end
    end

    // Pattern load beats mode write beats tick; ping-pong turns around after
    // NumLeds-1 steps so the lit bit visits both end positions exactly once.
    always_comb begin
        w_led_nxt = r_led;
        w_dir_nxt = r_dir;
        w_idx_nxt = r_idx;
        if (w_wr_pattern) begin
            w_led_nxt = w_wdata[NumLeds-1:0];
            w_dir_nxt = DIR_LEFT;
            w_idx_nxt = '0;
        end else if (w_wr_mode) begin
            w_dir_nxt = DIR_LEFT;
            w_idx_nxt = '0;
        end else if (w_tick) begin
            case (r_mode)
                MODE_ROTL: w_led_nxt = rot_l(r_led);
                MODE_ROTR: w_led_nxt = rot_r(r_led);
                MODE_PINGPONG: begin
                    w_led_nxt = (r_dir == DIR_LEFT) ? rot_l(r_led) : rot_r(r_led);
                    if (r_idx == c_idx_last) begin
                        w_idx_nxt = '0;
                        w_dir_nxt = (r_dir == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
                default: w_led_nxt = r_led;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pattern <= c_pattern_rst;
            r_mode    <= MODE_OFF;
            r_presc   <= '0;
            r_led     <= c_pattern_rst;
            r_steps   <= '0;
            r_dir     <= DIR_LEFT;
            r_idx     <= '0;
        end else begin
            if (w_wr_pattern) r_pattern <= w_wdata[NumLeds-1:0];
            if (w_wr_mode)    r_mode    <= rlight_mode_e'(w_wdata[1:0]);
            if (w_wr_presc)   r_presc   <= w_wdata[PrescW-1:0];
            if (w_wr_steps) begin
                r_steps <= '0;
            end else if (w_tick) begin
                r_steps <= r_steps + 32'd1;
            end
            r_led <= w_led_nxt;
            r_dir <= w_dir_nxt;
            r_idx <= w_idx_nxt;
        end
    end

    assign led_o = r_led;

endmodule

`default_nettype wire

// File: tb/tb_rlight_multi.sv
// ============================================================================
// Module : tb_rlight_multi
// Brief  : Self-checking bench for rlight_multi against a tick-count model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rlight_multi;
    import tlul_pkg::*;

    localparam int N = 8;
    localparam logic [31:0] A_PATTERN = 32'h00;
    localparam logic [31:0] A_MODE    = 32'h04;
    localparam logic [31:0] A_PRESC   = 32'h08;
    localparam logic [31:0] A_OUTPUT  = 32'h0C;
    localparam logic [31:0] A_STEPS   = 32'h10;

    logic         clk_i = 1'b0;
    logic         rst_i;
    tl_h2d_t      tl_i;
    tl_d2h_t      tl_o;
    logic [N-1:0] led_o;

    int checks = 0;
    int passed = 0;

    rlight_multi #(.NumLeds(N), .PrescW(32), .RegAw(5)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tl_i  (tl_i),
        .tl_o  (tl_o),
        .led_o (led_o)
    );

    always #5 clk_i = ~clk_i;

    // Net effect of `ticks` steps: rotations compose, so each mode reduces to
    // one left-rotation amount (ping-pong traces a triangle wave).
    function automatic logic [N-1:0] model_led(input logic [N-1:0] pat, input int mode, input int ticks);
        int sh;
        int p;
        sh = 0;
        case (mode)
            1: sh = ticks % N;
            2: sh = (N - (ticks % N)) % N;
            3: begin
                p  = ticks % (2 * (N - 1));
                sh = (p <= N - 1) ? p : (2 * (N - 1) - p);
            end
            default: sh = 0;
        endcase
        sh = sh % N;
        return (pat << sh) | (pat >> (N - sh));
    endfunction

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (tl_o.a_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
        end
        if (!ok) begin
            checks++;
            $display("FAIL bus_ready_timeout: a_ready=%b required 1", tl_o.a_ready);
        end
    endtask

    task automatic tl_write(input logic [31:0] addr, input logic [31:0] data);
        wait_ready();
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = PutFullData;
        tl_i.a_address = addr;
        tl_i.a_data    = data;
        tl_i.a_mask    = 4'hF;
        @(posedge clk_i); #1;
        tl_i.a_valid   = 1'b0;
    endtask

    task automatic tl_read(input logic [31:0] addr, output logic [31:0] data);
        wait_ready();
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = Get;
        tl_i.a_address = addr;
        tl_i.a_mask    = 4'hF;
        @(posedge clk_i); #1;
        tl_i.a_valid   = 1'b0;
        if (!tl_o.d_valid) begin
            checks++;
            $display("FAIL read_response addr=%h: d_valid=%b required 1", addr, tl_o.d_valid);
        end
        data = tl_o.d_data;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [6];
        logic [31:0] exps  [6];
        logic [31:0] d;
        addrs = '{A_OUTPUT, A_MODE, A_PRESC, A_STEPS, A_PATTERN, 32'h1C};
        exps  = '{32'h0F, 32'h0, 32'h0, 32'h0, 32'h0F, 32'h0};
        checks++;
        if (led_o !== 8'h0F) $display("FAIL reset_led: got %h required %h", led_o, 8'h0F);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            tl_read(addrs[i], d);
            checks++;
            if (d !== exps[i]) $display("FAIL reset_read addr=%h: got %h required %h", addrs[i], d, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_rotl();
        logic [N-1:0] e;
        logic [31:0]  d;
        tl_write(A_MODE, 0);
        tl_write(A_STEPS, 0);
        tl_write(A_PRESC, 2);
        tl_write(A_PATTERN, 32'h01);
        tl_write(A_MODE, 1);
        for (int m = 1; m <= 24; m++) begin
            @(posedge clk_i); #1;
            e = model_led(8'h01, 1, m / 3);
            checks++;
            if (led_o !== e) $display("FAIL rotl cycle %0d: got %h required %h", m, led_o, e);
            else passed++;
        end
        tl_read(A_STEPS, d);
        checks++;
        if (d !== 32'd8) $display("FAIL rotl_steps: got %0d required 8", d);
        else passed++;
    endtask

    task automatic test_rotr();
        logic [N-1:0] tab [3];
        tab = '{8'hC0, 8'h60, 8'h30};
        tl_write(A_MODE, 0);
        tl_write(A_PRESC, 0);
        tl_write(A_PATTERN, 32'h81);
        tl_write(A_MODE, 2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            checks++;
            if (led_o !== tab[i]) $display("FAIL rotr step %0d: got %h required %h", i + 1, led_o, tab[i]);
            else passed++;
        end
    endtask

    task automatic test_pingpong();
        logic [N-1:0] e;
        tl_write(A_MODE, 0);
        tl_write(A_PRESC, 0);
        tl_write(A_PATTERN, 32'h01);
        tl_write(A_MODE, 3);
        for (int t = 1; t <= 16; t++) begin
            @(posedge clk_i); #1;
            e = model_led(8'h01, 3, t);
            checks++;
            if (led_o !== e) $display("FAIL pingpong tick %0d: got %h required %h", t, led_o, e);
            else passed++;
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        tl_write(A_MODE, 0);
        tl_write(A_STEPS, 0);
        tl_write(A_PRESC, 3);
        tl_write(A_PATTERN, 32'h01);
        tl_write(A_MODE, 1);
        // Fourth cycle after the mode write is a tick cycle.
        repeat (3) begin @(posedge clk_i); #1; end
        tl_write(A_PATTERN, 32'h55);
        checks++;
        if (led_o !== 8'h55) $display("FAIL pattern_on_tick: got %h required 55", led_o);
        else passed++;
        repeat (3) begin @(posedge clk_i); #1; end
        checks++;
        if (led_o !== 8'h55) $display("FAIL presc_restart_hold: got %h required 55", led_o);
        else passed++;
        @(posedge clk_i); #1;
        checks++;
        if (led_o !== 8'hAA) $display("FAIL presc_restart_tick: got %h required aa", led_o);
        else passed++;

        repeat (3) begin @(posedge clk_i); #1; end
        tl_write(A_STEPS, 0);
        checks++;
        if (led_o !== 8'h55) $display("FAIL steps_write_tick_led: got %h required 55", led_o);
        else passed++;
        tl_read(A_STEPS, d);
        checks++;
        if (d !== 32'd0) $display("FAIL steps_clear_wins: got %0d required 0", d);
        else passed++;

        repeat (2) begin @(posedge clk_i); #1; end
        tl_write(A_MODE, 0);
        repeat (20) begin @(posedge clk_i); #1; end
        checks++;
        if (led_o !== 8'hAA) $display("FAIL off_freeze_led: got %h required aa", led_o);
        else passed++;
        tl_read(A_STEPS, d);
        checks++;
        if (d !== 32'd1) $display("FAIL off_freeze_steps: got %0d required 1", d);
        else passed++;
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        tl_write(A_MODE, 0);
        tl_write(A_PRESC, 5);
        tl_write(A_PATTERN, 32'h01);
        tl_write(A_MODE, 1);
        repeat (15) begin @(posedge clk_i); #1; end
        checks++;
        if (led_o !== 8'h04) $display("FAIL pre_reset_led: got %h required 04", led_o);
        else passed++;
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (led_o !== 8'h0F) $display("FAIL async_reset_led: got %h required 0f", led_o);
        else passed++;
        #1 rst_i = 1'b0;
        @(posedge clk_i); #1;
        tl_read(A_MODE, d);
        checks++;
        if (d !== 32'd0) $display("FAIL async_reset_mode: got %h required 0", d);
        else passed++;
        tl_read(A_STEPS, d);
        checks++;
        if (d !== 32'd0) $display("FAIL async_reset_steps: got %h required 0", d);
        else passed++;
        tl_read(A_OUTPUT, d);
        checks++;
        if (d !== 32'h0F) $display("FAIL async_reset_output: got %h required 0f", d);
        else passed++;
    endtask

    task automatic test_random();
        logic [N-1:0] pat;
        logic [N-1:0] e;
        logic [31:0]  d;
        int mode;
        int presc;
        int m;
        for (int it = 0; it < 10; it++) begin
            pat   = N'($urandom);
            mode  = int'($urandom_range(1, 3));
            presc = int'($urandom_range(0, 4));
            m     = int'($urandom_range(0, 30));
            tl_write(A_MODE, 0);
            tl_write(A_STEPS, 0);
            tl_write(A_PRESC, 32'(presc));
            tl_write(A_PATTERN, 32'(pat));
            tl_write(A_MODE, 32'(mode));
            repeat (m) begin @(posedge clk_i); #1; end
            e = model_led(pat, mode, m / (presc + 1));
            checks++;
            if (led_o !== e)
                $display("FAIL random it=%0d pat=%h mode=%0d presc=%0d cyc=%0d: got %h required %h",
                         it, pat, mode, presc, m, led_o, e);
            else passed++;
            tl_read(A_STEPS, d);
            checks++;
            if (d !== 32'(m / (presc + 1)))
                $display("FAIL random_steps it=%0d: got %0d required %0d", it, d, m / (presc + 1));
            else passed++;
        end
    endtask

    initial begin
        tl_i         = '0;
        tl_i.d_ready = 1'b1;
        rst_i        = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i); #1;
        test_reset();
        test_rotl();
        test_rotr();
        test_pingpong();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
